// File: rtl/bcd_display_scan_pkg.sv
// bcd_display_scan_pkg: shared seven-segment codes, digit-enable codes and scan states for the display path.
package bcd_display_scan_pkg;
    typedef enum logic [1:0] {S_ONES, S_GAP1, S_TENS, S_GAP0} scan_state_e;
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [1:0] AN_ONES  = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_OFF   = 2'b11;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
module seg7_decode
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: latches two BCD digits and time-multiplexes them onto a common-anode display with blanking gaps.
// Define LEAD_ZERO_BLANK_EN to keep the display dark during the tens phase when the tens digit is 0.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       busy_tens
);
    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW = $clog2((MAXC > 2) ? MAXC : 2);
    localparam bit NOGAP = (BLANK_CYC == 0);
    localparam logic [CW-1:0] LIT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    scan_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] ones_q, ones_d, tens_q, tens_d;
    logic [6:0] seg_q, seg_d, ones_seg, tens_seg;
    logic [1:0] an_q, an_d;
    logic busy_q, busy_d;
    logic lit, last, blank_tens, show_tens;

    seg7_decode u_ones (.bcd(ones_q), .seg(ones_seg));
    seg7_decode u_tens (.bcd(tens_q), .seg(tens_seg));

`ifdef LEAD_ZERO_BLANK_EN
    assign blank_tens = (tens_q == 4'd0);
`else
    assign blank_tens = 1'b0;
`endif

    always_comb begin
        lit       = (state_q == S_ONES) || (state_q == S_TENS);
        last      = (cnt_q == (lit ? LIT_LAST : GAP_LAST));
        cnt_d     = last ? '0 : cnt_q + 1'b1;
        state_d   = !last                ? state_q :
                    (state_q == S_ONES)  ? (NOGAP ? S_TENS : S_GAP1) :
                    (state_q == S_GAP1)  ? S_TENS :
                    (state_q == S_TENS)  ? (NOGAP ? S_ONES : S_GAP0) : S_ONES;
        ones_d    = ld ? ones : ones_q;
        tens_d    = ld ? tens : tens_q;
        // blanked leading zero keeps tens timing, only the drive is suppressed
        show_tens = (state_q == S_TENS) && !blank_tens;
        seg_d     = (state_q == S_ONES) ? ones_seg : show_tens ? tens_seg : SEG_OFF;
        an_d      = (state_q == S_ONES) ? AN_ONES  : show_tens ? AN_TENS  : AN_OFF;
        busy_d    = (state_q == S_TENS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ONES;
            cnt_q   <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            busy_q  <= busy_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign busy_tens = busy_q;
endmodule
